implication_queue: RTL and testbench

Parametrised first-word-fall-through queue of BCP implications (variable index plus assigned value) between the clause evaluators and the assignment/trail logic of the BCP accelerator. It fixes pointer wrap and occupancy at any power-of-two depth, accepts a read and a write in the same cycle, and reports overflow. It optionally performs an associative check of each incoming implication against the queued entries: duplicates are dropped and opposite-polarity implications are flagged as a conflict.

---
 rtl/implication_queue.sv | 153 +++++++++++++++
 tb/tb_implication_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/implication_queue.sv
// FWFT queue of BCP implications {variable, value} with occupancy, overflow and
// optional duplicate/conflict filtering (IMPLICATION_QUEUE_DEDUP_EN).
module implication_queue #(
    parameter int unsigned FORMULA_MAX_VARIABLE  = 20,
    parameter int unsigned VARIABLE_ENCODING_LEN = $clog2(FORMULA_MAX_VARIABLE + 1),
    parameter int unsigned WIDTH                 = VARIABLE_ENCODING_LEN + 1,
    parameter int unsigned BUFFER_SIZE           = 16,
    parameter int unsigned BUFFER_SIZE_ADDR_LEN  = $clog2(BUFFER_SIZE)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             en_i,
    input  logic                             clear_i,
    input  logic [WIDTH-1:0]                 implication_i,
    input  logic                             wr_i,
    input  logic                             rd_i,
    output logic [WIDTH-1:0]                 implication_o,
    output logic                             empty_o,
    output logic                             full_o,
    output logic [BUFFER_SIZE_ADDR_LEN:0]    count_o,
    output logic                             drop_o,
    output logic                             conflict_o,
    output logic [VARIABLE_ENCODING_LEN-1:0] conflict_var_o,
    output logic                             overflow_o
);

    localparam int unsigned PTR_W = BUFFER_SIZE_ADDR_LEN + 1;
    localparam int unsigned AW    = BUFFER_SIZE_ADDR_LEN;

    logic [WIDTH-1:0] mem_q [BUFFER_SIZE];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [PTR_W-1:0] count;
    logic [AW-1:0]    wr_idx, rd_idx;
    logic             wr_req, pop_acc, push_acc;
    logic             match, dup_hit, opp_hit;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign wr_idx  = wr_ptr_q[AW-1:0];
    assign rd_idx  = rd_ptr_q[AW-1:0];
    assign empty_o = (count == '0);
    assign full_o  = (count == PTR_W'(BUFFER_SIZE));
    assign count_o = count;
    assign overflow_o    = overflow_q;
    assign implication_o = empty_o ? '0 : mem_q[rd_idx];

    // Handshake decode on current-cycle occupancy (no look-ahead)
    assign wr_req   = wr_i & en_i;
    assign pop_acc  = rd_i & en_i & ~empty_o;
    assign push_acc = wr_req & ~full_o & ~match;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (clear_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
        end else begin
            wr_ptr_d   = wr_ptr_q + PTR_W'(push_acc);
            rd_ptr_d   = rd_ptr_q + PTR_W'(pop_acc);
            overflow_d = overflow_q | (wr_req & full_o & ~match);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage needs no reset; visibility is governed by the pointers
    always_ff @(posedge clk_i) begin
        if (push_acc && !clear_i) begin
            mem_q[wr_idx] <= implication_i;
        end
    end

`ifdef IMPLICATION_QUEUE_DEDUP_EN
    logic [BUFFER_SIZE-1:0]           valid_q, valid_d, hit_same, hit_diff;
    logic                             drop_q, drop_d, conflict_q, conflict_d;
    logic [VARIABLE_ENCODING_LEN-1:0] conflict_var_q, conflict_var_d;

    // Associative compare; an entry being popped this cycle still counts
    always_comb begin
        hit_same = '0;
        hit_diff = '0;
        for (int i = 0; i < int'(BUFFER_SIZE); i++) begin
            if (valid_q[i] && (mem_q[i][WIDTH-1:1] == implication_i[WIDTH-1:1])) begin
                hit_same[i] = (mem_q[i][0] == implication_i[0]);
                hit_diff[i] = (mem_q[i][0] != implication_i[0]);
            end
        end
    end

    assign match   = wr_req & (|(hit_same | hit_diff));
    assign dup_hit = wr_req & (|hit_same);
    assign opp_hit = wr_req & ~(|hit_same) & (|hit_diff);

    always_comb begin
        valid_d        = valid_q;
        drop_d         = 1'b0;
        conflict_d     = conflict_q;
        conflict_var_d = conflict_var_q;
        if (clear_i) begin
            valid_d        = '0;
            conflict_d     = 1'b0;
            conflict_var_d = '0;
        end else begin
            if (pop_acc)  valid_d[rd_idx] = 1'b0;
            if (push_acc) valid_d[wr_idx] = 1'b1;
            drop_d = dup_hit;
            if (opp_hit && !conflict_q) begin
                conflict_d     = 1'b1;
                conflict_var_d = implication_i[WIDTH-1:1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q        <= '0;
            drop_q         <= 1'b0;
            conflict_q     <= 1'b0;
            conflict_var_q <= '0;
        end else begin
            valid_q        <= valid_d;
            drop_q         <= drop_d;
            conflict_q     <= conflict_d;
            conflict_var_q <= conflict_var_d;
        end
    end

    assign drop_o         = drop_q;
    assign conflict_o     = conflict_q;
    assign conflict_var_o = conflict_var_q;
`else
    assign match          = 1'b0;
    assign dup_hit        = 1'b0;
    assign opp_hit        = 1'b0;
    assign drop_o         = 1'b0;
    assign conflict_o     = 1'b0;
    assign conflict_var_o = '0;
`endif

endmodule

// File: tb/tb_implication_queue.sv
// Scoreboard bench for implication_queue: stimulus pushes expected heads, a
// negedge monitor checks each consumed head; status checked after each edge.
module tb_implication_queue;

    localparam int unsigned W  = 6;
    localparam int unsigned VW = 5;

    logic          clk_i, rst_ni, en_i, clear_i, wr_i, rd_i;
    logic [W-1:0]  implication_i, implication_o;
    logic          empty_o, full_o, drop_o, conflict_o, overflow_o;
    logic [4:0]    count_o;
    logic [VW-1:0] conflict_var_o;

    implication_queue dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .clear_i(clear_i),
        .implication_i(implication_i), .wr_i(wr_i), .rd_i(rd_i),
        .implication_o(implication_o), .empty_o(empty_o), .full_o(full_o),
        .count_o(count_o), .drop_o(drop_o), .conflict_o(conflict_o),
        .conflict_var_o(conflict_var_o), .overflow_o(overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [W-1:0] exp_q[$];
    int total = 0, bad = 0;
    int mon_total = 0, mon_bad = 0;

    // Monitor: every head consumed by an accepted pop must match the model
    always @(negedge clk_i) begin
        if (rst_ni && en_i && !clear_i && rd_i && !empty_o) begin
            mon_total++;
            if (exp_q.size() == 0) begin
                mon_bad++;
                $display("FAIL pop_head: got %02h but model queue is empty", implication_o);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (implication_o !== e) begin
                    mon_bad++;
                    $display("FAIL pop_head: got %02h expected %02h", implication_o, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock of stimulus; acc says whether the model expects the push to land
    task automatic step(input logic w, input logic r, input logic [W-1:0] d, input logic acc);
        wr_i = w; rd_i = r; implication_i = d;
        if (acc) exp_q.push_back(d);
        @(posedge clk_i); #1;
        wr_i = 1'b0; rd_i = 1'b0;
    endtask

    function automatic logic [W-1:0] wrap_val(input int k);
        logic [VW-1:0] v;
        logic [31:0]   kk;
        kk = 32'(k);
        v  = VW'((k % 20) + 1);
        return {v, kk[0]};
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_empty"},    int'(empty_o), 1);
        chk({tag, "_full"},     int'(full_o), 0);
        chk({tag, "_count"},    int'(count_o), 0);
        chk({tag, "_head"},     int'(implication_o), 0);
        chk({tag, "_drop"},     int'(drop_o), 0);
        chk({tag, "_conflict"}, int'(conflict_o), 0);
        chk({tag, "_cvar"},     int'(conflict_var_o), 0);
        chk({tag, "_overflow"}, int'(overflow_o), 0);
    endtask

    initial begin
        int n;
        rst_ni = 1'b0; en_i = 1'b1; clear_i = 1'b0;
        wr_i = 1'b0; rd_i = 1'b0; implication_i = '0;
        #12;
        chk_reset_vals("rst");
        #1 rst_ni = 1'b1;

        // Basic FWFT order, plus enable gating
        en_i = 1'b0;
        step(1'b1, 1'b0, 6'h05, 1'b0);
        chk("en_low_count", int'(count_o), 0);
        en_i = 1'b1;
        step(1'b1, 1'b0, 6'h05, 1'b1);
        step(1'b1, 1'b0, 6'h0A, 1'b1);
        step(1'b1, 1'b0, 6'h11, 1'b1);
        chk("basic_count", int'(count_o), 3);
        chk("basic_head", int'(implication_o), 'h05);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, 1'b0);
        chk("basic_empty", int'(empty_o), 1);
        chk("basic_head0", int'(implication_o), 0);

        // Fill to full, overflow, push+pop while full
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, W'((i + 1) << 1), 1'b1);
        chk("fill_full", int'(full_o), 1);
        chk("fill_count", int'(count_o), 16);
        step(1'b1, 1'b0, 6'h22, 1'b0);
        chk("ovf_flag", int'(overflow_o), 1);
        chk("ovf_count", int'(count_o), 16);
        step(1'b1, 1'b1, 6'h24, 1'b0);
        chk("fullrw_count", int'(count_o), 15);
        chk("fullrw_ovf", int'(overflow_o), 1);
        chk("fullrw_full", int'(full_o), 0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, '0, 1'b0);
        chk("drain_empty", int'(empty_o), 1);

        // Pointer wrap at steady occupancy 3
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, wrap_val(k), 1'b1);
        for (int k = 3; k < 40; k++) begin
            step(1'b1, 1'b1, wrap_val(k), 1'b1);
            chk("wrap_count", int'(count_o), 3);
        end
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, '0, 1'b0);
        chk("wrap_empty", int'(empty_o), 1);

        // Duplicate and conflict filtering
`ifdef IMPLICATION_QUEUE_DEDUP_EN
        step(1'b1, 1'b0, 6'h07, 1'b1);
        step(1'b1, 1'b0, 6'h07, 1'b0);
        chk("dup_drop", int'(drop_o), 1);
        chk("dup_count", int'(count_o), 1);
        chk("dup_ovf", int'(overflow_o), 1);
        step(1'b1, 1'b0, 6'h06, 1'b0);
        chk("drop_pulse_end", int'(drop_o), 0);
        chk("cfl_flag", int'(conflict_o), 1);
        chk("cfl_var", int'(conflict_var_o), 3);
        chk("cfl_count", int'(count_o), 1);
`else
        step(1'b1, 1'b0, 6'h07, 1'b1);
        step(1'b1, 1'b0, 6'h07, 1'b1);
        chk("dup_drop", int'(drop_o), 0);
        chk("dup_count", int'(count_o), 2);
        step(1'b1, 1'b0, 6'h06, 1'b1);
        chk("cfl_flag", int'(conflict_o), 0);
        chk("cfl_count", int'(count_o), 3);
`endif
        n = exp_q.size();
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, '0, 1'b0);
        chk("dedup_empty", int'(empty_o), 1);

        // Read+write on empty, then synchronous clear
        step(1'b1, 1'b1, 6'h09, 1'b1);
        chk("erw_count", int'(count_o), 1);
        chk("erw_head", int'(implication_o), 'h09);
        clear_i = 1'b1;
        step(1'b0, 1'b0, '0, 1'b0);
        clear_i = 1'b0;
        exp_q.delete();
        chk("clr_empty", int'(empty_o), 1);
        chk("clr_count", int'(count_o), 0);
        chk("clr_conflict", int'(conflict_o), 0);
        chk("clr_overflow", int'(overflow_o), 0);

        // Asynchronous reset with entries queued
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'(((i + 2) << 1) | 1), 1'b1);
        chk("pre_rst_count", int'(count_o), 5);
        #2 rst_ni = 1'b0;
        #1 chk_reset_vals("arst");
        exp_q.delete();
        #2 rst_ni = 1'b1;
        step(1'b1, 1'b0, 6'h2B, 1'b1);
        chk("post_rst_count", int'(count_o), 1);
        chk("post_rst_head", int'(implication_o), 'h2B);
        step(1'b0, 1'b1, '0, 1'b0);

        #3;
        chk("model_drained", exp_q.size(), 0);
        total = total + mon_total;
        bad   = bad + mon_bad;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
